branch_recovery_ctrl: RTL

Sequencing controller between the fetch-stage branch predictor and the decode-stage branch resolution logic. It holds every in-flight prediction in a small ordered queue and checks each one against its resolved outcome. It issues the registered predictor-update beat for each resolved branch. On a misprediction it drives the flush/redirect sequence.

---
 rtl/branch_recovery_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/branch_recovery_ctrl.sv
// Branch recovery controller: ordered queue of in-flight predictions, resolve checking,
// predictor-update beat and flush/redirect sequencing. Optional macro: BRC_PC_CHECK_EN.
module branch_recovery_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_pred_taken,
  input  logic [31:0]      fetch_pred_target,
  input  logic             resolve_valid,
  input  logic [31:0]      resolve_pc,
  input  logic             resolve_taken,
  input  logic [31:0]      resolve_target,
  output logic             q_full,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             desync_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [AW:0]   QFULL  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TLOAD  = TW'(FLUSH_CYCLES);
  localparam logic [TW-1:0] TLAST  = TW'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic        predTaken;
    logic [31:0] predTarget;
  } entry_t;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state;
  logic [TW-1:0]   flushTimer;
  logic [AW-1:0]   wrPtr, rdPtr;
  logic [AW:0]     count;
  entry_t          q [DEPTH];
  entry_t          head;

  logic qEmpty, running, pushEn, resAcc, popEn;
  logic dirMiss, pcMismatch, mispredict;

  assign head    = q[rdPtr];
  assign qEmpty  = (count == '0);
  assign q_full  = (count == QFULL);
  assign running = (state == RUN);
  assign pushEn  = fetch_valid && !q_full && running;
  assign resAcc  = resolve_valid && running;
  assign popEn   = resAcc && !qEmpty;

  // An empty-queue resolve behaves like a predicted not-taken branch.
  assign dirMiss = qEmpty ? resolve_taken
                          : ((head.predTaken != resolve_taken) ||
                             (resolve_taken && (head.predTarget != resolve_target)));

`ifdef BRC_PC_CHECK_EN
  assign pcMismatch = !qEmpty && (resolve_pc != head.pc);
`else
  assign pcMismatch = 1'b0;
`endif

  assign mispredict = resAcc && (dirMiss || pcMismatch);

  // Storage needs no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (pushEn) q[wrPtr] <= '{pc: fetch_pc, predTaken: fetch_pred_taken,
                              predTarget: fetch_pred_target};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (mispredict) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      flushTimer       <= '0;
      flush            <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        RUN: begin
          if (mispredict) begin
            state          <= FLUSH;
            flushTimer     <= TLOAD;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= resolve_taken ? resolve_target : (resolve_pc + 32'd4);
            if (mispredict_count != '1) mispredict_count <= mispredict_count + 1'b1;
          end
        end
        FLUSH: begin
          flushTimer <= flushTimer - 1'b1;
          if (flushTimer == TLAST) begin
            state <= RUN;
            flush <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid  <= 1'b0;
      upd_pc     <= '0;
      upd_taken  <= 1'b0;
      upd_target <= '0;
    end else begin
      upd_valid <= resAcc;
      if (resAcc) begin
        upd_pc     <= qEmpty ? resolve_pc : head.pc;
        upd_taken  <= resolve_taken;
        upd_target <= resolve_target;
      end
    end
  end

`ifdef BRC_PC_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    desync_err <= 1'b0;
    else if (resAcc && pcMismatch) desync_err <= 1'b1;
  end
`else
  assign desync_err = 1'b0;
`endif

endmodule
